serial_adder_nb: RTL and testbench
==================================

# serial_adder_nb

Bit-serial N-bit adder built around the 1-bit full-adder slice (`fullAdder_1b`), which it instantiates internally.
- A start pulse loads two operands and a carry-in.
- The block then feeds one operand bit pair per clock, LSB first, into the slice, registering the slice's carry between cycles.
- It posts the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- It is the control and datapath stage that sits directly upstream of the full-adder slice and consumes its S/C_out every cycle.

## Interface
Parameters:
- WIDTH, 16, operand/sum width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-low; one clock, async active-low reset.
- start  in  1  request to begin an addition; sampled on rising edge.
- a  in  WIDTH  operand A; sampled only when start is accepted.
- b  in  WIDTH  operand B; sampled only when start is accepted.
- c_in  in  1  carry-in; sampled only when start is accepted.
- busy  out  1  high while bits are being processed (RUN state).
- done  out  1  one-cycle pulse; sum/c_out valid from this cycle on.
- sum  out  WIDTH  result register; holds the last completed sum.
- c_out  out  1  carry-out of the last completed addition.

## Operation
State machine has three states: IDLE, RUN and DONE.

IDLE:
- start=1 loads a_sh←a, b_sh←b, carry←c_in, cnt←0, and moves to RUN.
- start=0 stays in IDLE.

RUN, each cycle:
- The slice inputs are A=a_sh[0], B=b_sh[0], C_in=carry.
- a_sh and b_sh shift right by one (zero fill).
- acc shifts right with the slice's S inserted at bit WIDTH-1.
- carry←C_out and cnt←cnt+1.
- start is ignored.

RUN exit:
- When cnt==WIDTH-1, the final bit is processed.
- On that edge: sum←{S, acc[WIDTH-1:1]}, c_out←C_out, and the state moves to DONE.

DONE:
- done=1 for exactly this cycle.
- If start=1, the cycle behaves as IDLE with start accepted: new operands load and the state goes to RUN (back-to-back operation).
- Otherwise the state returns to IDLE.

Outputs and registers:
- sum and c_out change only on the RUN→DONE edge.
- They hold through IDLE and through the following RUN.
- cnt is $clog2(WIDTH)+1 bits wide; no wrap occurs within a legal run.
- Arithmetic is unsigned modulo 2^WIDTH; the carry out of bit WIDTH-1 goes to c_out.

Reset (rst=0), asynchronously:
- state→IDLE.
- busy=0, done=0, sum=0, c_out=0.
- a_sh, b_sh, acc, carry and cnt are all cleared to 0.
- Reset during RUN abandons the addition; no done pulse is produced for it.

## Timing
- start is sampled high at edge E0 (state IDLE or DONE).
- busy is high from E0 through edge E0+WIDTH.
- At E0+WIDTH: sum and c_out update, done rises, busy falls.
- done falls at E0+WIDTH+1.
- Latency from the start-accept edge to done is WIDTH cycles.
- Throughput is one addition per WIDTH+1 cycles; this remains WIDTH+1 with back-to-back start asserted during DONE.
- There is no combinational path from inputs to outputs; all outputs are registered.

## Configuration
Macro: SERIAL_ADDER_OVF_EN.

Defined:
- Adds output port ovf (out, 1 bit): the signed two's-complement overflow of the last completed addition.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- It is captured on the RUN→DONE edge alongside sum.
- It resets to 0 and holds like sum.

Undefined:
- The ovf port and its register are absent.
- All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16.
- a=0x0001, b=0xFFFF, c_in=0, start pulsed one cycle → done exactly 16 cycles after the accept edge; sum=0x0000, c_out=1; busy high for 16 cycles.
- a=0x1234, b=0x4321, c_in=1 → sum=0x5556, c_out=0.
- Addition 0x00FF+0x0001 in progress, start re-asserted with a=0xAAAA at cycle 5 → ignored; result is 0x0100, c_out=0.
- rst driven low at cycle 8 of a RUN, asynchronously between edges → busy, done, sum and c_out are 0 immediately.
  - No done pulse follows.
  - A fresh start after release gives the correct result.
- Back-to-back:
  - Accept 0xFFFF+0x0001, c_in=0, and hold start high in the DONE cycle with a=0x0002, b=0x0003.
  - First done shows sum 0x0000, c_out=1.
  - Second done arrives 17 cycles later with sum 0x0005, c_out=0.
- With SERIAL_ADDER_OVF_EN defined:
  - 0x7FFF+0x0001 → sum=0x8000, c_out=0, ovf=1.
  - 0x8000+0xFFFF → sum=0x7FFF, c_out=1, ovf=1.
  - 0x0003+0x0004 → ovf=0.

Source files
------------

// File: rtl/serial_adder_nb.sv
// serial_adder_nb: bit-serial WIDTH-bit unsigned adder.
//
// A start pulse loads operands a, b and carry-in c_in. One bit pair per clock,
// LSB first, then passes through a 1-bit full-adder slice (fullAdder_1b). The
// slice's carry is registered between cycles. After WIDTH cycles the sum and
// carry-out are posted, and done pulses for one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   start  begin an addition (accepted in IDLE or DONE, ignored in RUN)
//   a, b   operands, sampled when start is accepted
//   c_in   carry-in, sampled when start is accepted
//   busy   high while bits are being processed
//   done   one-cycle pulse; sum/c_out valid from this cycle on
//   sum    last completed sum (modulo 2^WIDTH)
//   c_out  carry-out of the last completed addition
//   ovf    (only with SERIAL_ADDER_OVF_EN) signed overflow of the last addition
//
// Optional feature macro: SERIAL_ADDER_OVF_EN.

// 1-bit full-adder slice.
module fullAdder_1b (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S,
    output logic C_out
);
    assign S     = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder_nb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
    logic             carry_q, c_out_q;
    logic [CntW-1:0]  cnt_q;

    logic fa_s, fa_c;
    logic load, step, last;

    // acc_q[0] is shifted out on the final bit and never consumed.
    logic unused_acc_lsb;
    assign unused_acc_lsb = acc_q[0];

    fullAdder_1b u_fa (
        .A     (a_sh_q[0]),
        .B     (b_sh_q[0]),
        .C_in  (carry_q),
        .S     (fa_s),
        .C_out (fa_c)
    );

    // Next-state and datapath enables.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = (cnt_q == CntLast);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Back-to-back: a start seen in DONE is accepted directly.
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                carry_q <= c_in;
                cnt_q   <= '0;
            end else if (step) begin
                a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                acc_q   <= {fa_s, acc_q[WIDTH-1:1]};
                carry_q <= fa_c;
                cnt_q   <= cnt_q + CntW'(1);
                if (last) begin
                    sum_q   <= {fa_s, acc_q[WIDTH-1:1]};
                    c_out_q <= fa_c;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the final bit, carry_q is the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= carry_q ^ fa_c;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_nb.sv
// Self-checking bench for serial_adder_nb with WIDTH=16.
// Inputs are driven on the falling edge or #1 after the rising edge.
// Outputs are sampled on the falling edge.
module tb_serial_adder_nb;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf;
`endif

    int vectors;
    int miscompares;

    serial_adder_nb #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #12;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        vectors++;
        if (sum !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_sum: got %h want 0000", sum);
        end
        vectors++;
        if (c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c_out: got %b want 0", c_out);
        end
`ifdef SERIAL_ADDER_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full addition with latency, busy-length, result and done-width checks.
    task automatic test_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                            input logic [15:0] es, input logic ec, input logic eo,
                            input string name);
        int n;
        int busy_n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        c_in  = vc;
        @(posedge clk);
        #1 start = 1'b0;
        n      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) busy_n++;
        end
        vectors++;
        if (!seen || n != 17) begin
            miscompares++;
            $display("FAIL %s latency: got %0d edges (seen=%0d) want 16", name, n - 1, seen);
        end
        vectors++;
        if (busy_n != 16) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want 16", name, busy_n);
        end
        vectors++;
        if (sum !== es) begin
            miscompares++;
            $display("FAIL %s sum: got %h want %h", name, sum, es);
        end
        vectors++;
        if (c_out !== ec) begin
            miscompares++;
            $display("FAIL %s c_out: got %b want %b", name, c_out, ec);
        end
`ifdef SERIAL_ADDER_OVF_EN
        vectors++;
        if (ovf !== eo) begin
            miscompares++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, eo);
        end
`else
        if (eo === 1'bx) $display("note: %s ovf expectation undefined", name);
`endif
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    // A start pulse during RUN must not disturb the addition in flight.
    task automatic test_start_ignored();
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0001;
        c_in  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            if (n == 5) begin
                start = 1'b1;
                a     = 16'hAAAA;
                b     = 16'h5555;
                c_in  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        vectors++;
        if (!seen || n != 17) begin
            miscompares++;
            $display("FAIL ignore latency: got %0d edges (seen=%0d) want 16", n - 1, seen);
        end
        vectors++;
        if (sum !== 16'h0100) begin
            miscompares++;
            $display("FAIL ignore sum: got %h want 0100", sum);
        end
        vectors++;
        if (c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore c_out: got %b want 0", c_out);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore restarted: got busy=%b want 0", busy);
        end
    endtask

    // Asynchronous reset in the middle of RUN; expects held result FFFF/1 beforehand.
    task automatic test_reset_mid_run();
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        c_in  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst busy: got %b want 0", busy);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst done: got %b want 0", done);
        end
        vectors++;
        if (sum !== 16'h0000) begin
            miscompares++;
            $display("FAIL midrst sum: got %h want 0000", sum);
        end
        vectors++;
        if (c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst c_out: got %b want 0", c_out);
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 24; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midrst activity_after_reset: got done/busy high want none");
        end
    endtask

    // Start held during DONE launches the next addition with no idle cycle.
    task automatic test_back_to_back();
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        c_in  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n != 17) begin
            miscompares++;
            $display("FAIL b2b first_latency: got %0d edges (seen=%0d) want 16", n - 1, seen);
        end
        vectors++;
        if (sum !== 16'h0000 || c_out !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b first_result: got %h/%b want 0000/1", sum, c_out);
        end
        start = 1'b1;
        a     = 16'h0002;
        b     = 16'h0003;
        c_in  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b restart_busy: got %b want 1", busy);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n != 17) begin
            miscompares++;
            $display("FAIL b2b second_spacing: got %0d cycles (seen=%0d) want 17", n, seen);
        end
        vectors++;
        if (sum !== 16'h0005 || c_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b second_result: got %h/%b want 0005/0", sum, c_out);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        test_add(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "add_cin");
        test_start_ignored();
        test_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "add_ones");
        test_reset_mid_run();
        test_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "add_after_rst");
        test_back_to_back();
        test_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        test_add(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, "ovf_neg");
        test_add(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "ovf_none");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
